packet_drop_gate: RTL and testbench
===================================

// Module: packet_drop_gate
// PURPOSE
//  Final stage of the internal datapath. Records one keep/drop verdict per input packet
//  from the IP-ID window result, then applies it to the same packet on the FIFO-delayed
//  stream, suppressing dropped packets word-for-word. Feeds the top-level avln_st output.
//  Also exports the drop pulse and counters for the hex display.
// PARAMETERS
//  QDEPTH    16  verdict queue depth (packets in flight between input and FIFO output); power of 2
//  CTR_SIZE  32  width of drop_count and pass_count
// PORTS
//  sys_clk       in   1         single clock; every flop is on its rising edge
//  reset_n       in   1         async assert, active-low, sync deassert upstream
//  in            in   avln_st   undelayed input stream (valid/sop/eop qualify the verdict)
//  start         in   1         pulse: IPv4 header start in the current input packet
//  valid         in   1         pulse: IP-ID extracted; qualifies found in same cycle
//  found         in   1         IP-ID repeated in window => drop the packet
//  fifo_out      in   avln_st   FIFO-delayed copy of in
//  out           out  avln_st   gated stream, registered
//  drop          out  1         high with every out word of a dropped packet (incl. sop)
//  drop_count    out  CTR_SIZE  dropped packets, saturating
//  pass_count    out  CTR_SIZE  forwarded packets, saturating
//  q_overflow    out  1         sticky: verdict pushed while queue full
//  q_underrun    out  1         sticky: fifo_out.sop seen with queue empty
// BEHAVIOUR
//  Reset: out all fields 0, drop 0, counters 0, sticky flags 0, queue empty,
//   verdict latch 0, in_pkt 0, gate state IDLE.
//  Input side, per packet:
//   - in.valid & in.sop: clear verdict latch v, set in_pkt.
//   - valid & found & in_pkt: set v. start is informational; a packet with no valid
//     pulse keeps v=0 (pass).
//   - Push at in.valid & in.eop & in_pkt; pushed bit = v | (valid & found) in the same
//     cycle. Then clear in_pkt.
//   - sop while in_pkt (missing eop): push the old verdict first, then start the new packet.
//   - valid/found with in_pkt=0 is ignored.
//  Queue: FIFO of 1-bit verdicts, QDEPTH entries.
//   - Simultaneous push and pop is legal and leaves occupancy unchanged, including when full.
//   - Push when full and no pop: the push is discarded and q_overflow is set.
//  Output side, gate FSM clocked on fifo_out.valid words:
//   - IDLE: non-sop words are suppressed (out.valid=0).
//     On sop, pop the verdict:
//       verdict 1 -> DROP;
//       verdict 0 -> PASS;
//       queue empty -> PASS and set q_underrun (fail-open).
//   - PASS / DROP: on eop, return to IDLE.
//   - sop while in PASS/DROP: treat as an implicit eop, then pop again for the new packet.
//   - sop & eop in the same word (one-word packet): pop, forward or suppress, stay IDLE.
//  Output, 1-cycle latency:
//   - out <= fifo_out with valid forced to 0 when suppressed.
//   - drop <= 1 for every word of a dropped packet, aligned with where out would have been.
//   - Dropped words keep data/sop/eop registered but valid=0.
//  Counters, saturating at all-ones:
//   - drop_count increments once per dropped packet, on its sop.
//   - pass_count increments once per forwarded packet, on its sop.
//  Reset mid-packet: all state clears; the remaining words of the packet in flight are
//   suppressed in IDLE until the next sop.
//  Requirement on the FIFO: its delay must let a packet's eop enter before its sop exits.
//   If violated, q_underrun fires and the packet passes.
// TESTING
//  1. Three 8-word packets, no valid pulses -> all forwarded unchanged after 1 cycle;
//     pass_count=3, drop=0 throughout.
//  2. Packet 2 of 3 gets valid&found=1 at word 2 -> packet 2 fully suppressed, drop high
//     for its 8 words; drop_count=1, pass_count=2.
//  3. QDEPTH=4 with 5 packets queued before any fifo_out sop -> q_overflow=1;
//     fifo_out.sop with queue empty -> q_underrun=1 and the packet is forwarded.
//  4. Push and pop in the same cycle with the queue full -> no overflow, occupancy stays 4.
//  5. One-word packet (sop&eop) marked drop, then an input packet with missing eop followed
//     by a new sop -> correct verdict ordering, FSM back to IDLE.
//  6. Assert reset_n during word 4 of a dropped packet -> outputs and counters 0
//     asynchronously; words 5-8 suppressed; next packet forwarded normally.

Source files
------------

// File: rtl/packet_drop_gate.sv
// packet_drop_gate: records a keep/drop verdict per input packet and applies it
// to the same packet on the FIFO-delayed stream, suppressing dropped packets.
//
// Ports:
//   sys_clk, reset_n      clock, async active-low reset
//   in                    undelayed stream (valid/sop/eop delimit packets)
//   start, valid, found   IPv4 start (informational), IP-ID valid, repeat hit
//   fifo_out              FIFO-delayed copy of in
//   out, drop             gated stream and per-word drop flag (1-cycle latency)
//   drop_count/pass_count saturating packet counters
//   q_overflow/q_underrun sticky verdict-queue error flags

package pdg_pkg;
    typedef struct packed {
        logic        valid;
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } avln_st;
endpackage

module packet_drop_gate
    import pdg_pkg::*;
#(
    parameter int QDEPTH   = 16,
    parameter int CTR_SIZE = 32
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  avln_st              in,
    input  logic                start,
    input  logic                valid,
    input  logic                found,
    input  avln_st              fifo_out,
    output avln_st              out,
    output logic                drop,
    output logic [CTR_SIZE-1:0] drop_count,
    output logic [CTR_SIZE-1:0] pass_count,
    output logic                q_overflow,
    output logic                q_underrun
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, PASS, DROP} gate_t;

    gate_t               state_q, state_d;
    logic                v_q, v_d;
    logic                in_pkt_q, in_pkt_d;
    logic [QDEPTH-1:0]   mem_q, mem_d;
    logic [AW-1:0]       wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    avln_st              out_q, out_d;
    logic                drop_q, drop_d;
    logic [CTR_SIZE-1:0] dcnt_q, dcnt_d, pcnt_q, pcnt_d;
    logic                ovf_q, ovf_d, unr_q, unr_d;

    // start and the payload are not needed to form the verdict
    logic sig_unused;
    assign sig_unused = start ^ (^in.data);

    logic in_sop, in_eop, pkt_eff, v_eff, hit;
    logic push_a, push_b, first_bit;
    logic fo_sop, q_empty, pop, verdict;
    int   n_push, space, accepted;

    always_comb begin
        // input side: a sop in this word opens the packet immediately,
        // so a one-word packet can be judged and pushed in one cycle
        in_sop  = in.valid & in.sop;
        in_eop  = in.valid & in.eop;
        pkt_eff = in_pkt_q | in_sop;
        v_eff   = in_sop ? 1'b0 : v_q;
        hit     = valid & found & pkt_eff;
        // push_a closes a packet that lost its eop; push_b is the normal push
        push_a  = in_sop & in_pkt_q;
        push_b  = in_eop & pkt_eff;
        v_d      = v_eff | hit;
        in_pkt_d = pkt_eff & ~in_eop;

        fo_sop  = fifo_out.valid & fifo_out.sop;
        q_empty = (cnt_q == '0);
        pop     = fo_sop & ~q_empty;
        verdict = pop & mem_q[rp_q];

        // a slot freed by this cycle's pop is available to this cycle's push
        n_push   = int'(push_a) + int'(push_b);
        space    = QDEPTH - int'(cnt_q) + int'(pop);
        accepted = (n_push > space) ? space : n_push;
        first_bit = push_a ? v_q : (v_eff | hit);

        mem_d = mem_q;
        if (accepted >= 1) mem_d[wp_q] = first_bit;
        if (accepted == 2) mem_d[AW'(wp_q + AW'(1))] = v_eff | hit;
        wp_d  = wp_q + AW'(accepted);
        rp_d  = rp_q + AW'(pop);
        cnt_d = cnt_q + CW'(accepted) - CW'(pop);
        ovf_d = ovf_q | (n_push > space);

        // output side
        out_d   = fifo_out;
        drop_d  = 1'b0;
        state_d = state_q;
        dcnt_d  = dcnt_q;
        pcnt_d  = pcnt_q;
        unr_d   = unr_q;
        if (fifo_out.valid) begin
            if (fifo_out.sop) begin
                // empty queue fails open: the packet is forwarded
                if (q_empty) unr_d = 1'b1;
                out_d.valid = ~verdict;
                drop_d      = verdict;
                if (verdict) begin
                    if (dcnt_q != '1) dcnt_d = dcnt_q + CTR_SIZE'(1);
                end else begin
                    if (pcnt_q != '1) pcnt_d = pcnt_q + CTR_SIZE'(1);
                end
                if (fifo_out.eop) state_d = IDLE;
                else              state_d = verdict ? DROP : PASS;
            end else begin
                unique case (state_q)
                    PASS: begin
                        if (fifo_out.eop) state_d = IDLE;
                    end
                    DROP: begin
                        out_d.valid = 1'b0;
                        drop_d      = 1'b1;
                        if (fifo_out.eop) state_d = IDLE;
                    end
                    default: out_d.valid = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            v_q      <= 1'b0;
            in_pkt_q <= 1'b0;
            mem_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            drop_q   <= 1'b0;
            dcnt_q   <= '0;
            pcnt_q   <= '0;
            ovf_q    <= 1'b0;
            unr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            in_pkt_q <= in_pkt_d;
            mem_q    <= mem_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            dcnt_q   <= dcnt_d;
            pcnt_q   <= pcnt_d;
            ovf_q    <= ovf_d;
            unr_q    <= unr_d;
        end
    end

    assign out        = out_q;
    assign drop       = drop_q;
    assign drop_count = dcnt_q;
    assign pass_count = pcnt_q;
    assign q_overflow = ovf_q;
    assign q_underrun = unr_q;

endmodule

// File: tb/tb_packet_drop_gate.sv
// tb_packet_drop_gate: directed bench for packet_drop_gate (QDEPTH=4).
// The bench plays both the input stream and the FIFO-delayed stream.

module tb_packet_drop_gate;
    import pdg_pkg::*;

    localparam int QD = 4;
    localparam int CS = 32;

    logic          sys_clk = 1'b0;
    logic          reset_n;
    avln_st        in, fifo_out, out;
    logic          start, valid, found, drop, q_overflow, q_underrun;
    logic [CS-1:0] drop_count, pass_count;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    packet_drop_gate #(.QDEPTH(QD), .CTR_SIZE(CS)) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .in         (in),
        .start      (start),
        .valid      (valid),
        .found      (found),
        .fifo_out   (fifo_out),
        .out        (out),
        .drop       (drop),
        .drop_count (drop_count),
        .pass_count (pass_count),
        .q_overflow (q_overflow),
        .q_underrun (q_underrun)
    );

    function automatic avln_st wd(int p, int k, int n);
        avln_st w;
        w.valid = 1'b1;
        w.sop   = (k == 0);
        w.eop   = (k == n - 1);
        w.data  = {p[15:0], k[15:0]};
        return w;
    endfunction

    function automatic avln_st sup(avln_st w);
        avln_st r;
        r = w;
        r.valid = 1'b0;
        return r;
    endfunction

    task automatic step(input avln_st iw, input logic va, input logic fd,
                        input avln_st fw);
        @(negedge sys_clk);
        in = iw; valid = va; found = fd; start = va; fifo_out = fw;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        in = '0; fifo_out = '0; valid = 0; found = 0; start = 0;
        reset_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out !== '0) begin
            errors++; $display("FAIL rst_out got %h want 0", out);
        end
        checks++;
        if (drop !== 1'b0) begin
            errors++; $display("FAIL rst_drop got %b want 0", drop);
        end
        checks++;
        if (drop_count !== '0 || pass_count !== '0) begin
            errors++;
            $display("FAIL rst_cnt got %0d/%0d want 0/0", drop_count, pass_count);
        end
        checks++;
        if (q_overflow !== 1'b0 || q_underrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags got %b%b want 00", q_overflow, q_underrun);
        end
    endtask

    task automatic test_pass();
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 8; k++) step(wd(p, k, 8), 0, 0, '0);
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 8; k++) begin
                step('0, 0, 0, wd(p, k, 8));
                checks++;
                if (out !== wd(p, k, 8) || drop !== 1'b0) begin
                    errors++;
                    $display("FAIL pass_word p%0d k%0d got %h/%b want %h/0",
                             p, k, out, drop, wd(p, k, 8));
                end
            end
        checks++;
        if (pass_count !== 3 || drop_count !== 0) begin
            errors++;
            $display("FAIL pass_cnt got p%0d d%0d want p3 d0", pass_count, drop_count);
        end
    endtask

    task automatic test_drop();
        logic h;
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 8; k++) begin
                h = (p == 1 && k == 2);
                step(wd(p, k, 8), h, h, '0);
            end
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 8; k++) begin
                step('0, 0, 0, wd(p, k, 8));
                checks++;
                if (p == 1) begin
                    if (out !== sup(wd(p, k, 8)) || drop !== 1'b1) begin
                        errors++;
                        $display("FAIL drop_word k%0d got %h/%b want %h/1",
                                 k, out, drop, sup(wd(p, k, 8)));
                    end
                end else if (out !== wd(p, k, 8) || drop !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_keep p%0d k%0d got %h/%b want %h/0",
                             p, k, out, drop, wd(p, k, 8));
                end
            end
        checks++;
        if (pass_count !== 2 || drop_count !== 1) begin
            errors++;
            $display("FAIL drop_cnt got p%0d d%0d want p2 d1", pass_count, drop_count);
        end
    endtask

    task automatic test_overflow_underrun();
        logic h, ed;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            if (p == 4) begin
                checks++;
                if (q_overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_early got %b want 0", q_overflow);
                end
            end
            for (int k = 0; k < 2; k++) begin
                h = (p == 1 || p == 3 || p == 4) && k == 1;
                step(wd(p, k, 2), h, h, '0);
            end
        end
        checks++;
        if (q_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_set got %b want 1", q_overflow);
        end
        for (int p = 0; p < 5; p++) begin
            if (p == 4) begin
                checks++;
                if (q_underrun !== 1'b0) begin
                    errors++; $display("FAIL unr_early got %b want 0", q_underrun);
                end
            end
            ed = (p == 1 || p == 3);
            for (int k = 0; k < 2; k++) begin
                step('0, 0, 0, wd(p, k, 2));
                checks++;
                if (out !== (ed ? sup(wd(p, k, 2)) : wd(p, k, 2)) || drop !== ed) begin
                    errors++;
                    $display("FAIL ovf_word p%0d k%0d got %h/%b want drop %b",
                             p, k, out, drop, ed);
                end
            end
        end
        checks++;
        if (q_underrun !== 1'b1) begin
            errors++; $display("FAIL unr_set got %b want 1", q_underrun);
        end
        checks++;
        if (pass_count !== 3 || drop_count !== 2) begin
            errors++;
            $display("FAIL ovf_cnt got p%0d d%0d want p3 d2", pass_count, drop_count);
        end
    endtask

    task automatic test_full_push_pop();
        logic h, ed;
        do_reset();
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 2; k++) begin
                h = (p == 0 || p == 3) && k == 1;
                step(wd(p, k, 2), h, h, '0);
            end
        step(wd(4, 0, 2), 0, 0, '0);
        step(wd(4, 1, 2), 1, 1, wd(0, 0, 2));
        checks++;
        if (q_overflow !== 1'b0) begin
            errors++; $display("FAIL full_ovf got %b want 0", q_overflow);
        end
        checks++;
        if (out !== sup(wd(0, 0, 2)) || drop !== 1'b1) begin
            errors++; $display("FAIL full_pop0 got %h/%b want drop", out, drop);
        end
        step('0, 0, 0, wd(0, 1, 2));
        checks++;
        if (drop !== 1'b1 || out.valid !== 1'b0) begin
            errors++; $display("FAIL full_p0eop got v%b/%b want 0/1", out.valid, drop);
        end
        for (int p = 1; p < 5; p++) begin
            ed = (p == 3 || p == 4);
            for (int k = 0; k < 2; k++) begin
                step('0, 0, 0, wd(p, k, 2));
                checks++;
                if (out !== (ed ? sup(wd(p, k, 2)) : wd(p, k, 2)) || drop !== ed) begin
                    errors++;
                    $display("FAIL full_word p%0d k%0d got %h/%b want drop %b",
                             p, k, out, drop, ed);
                end
            end
        end
        checks++;
        if (q_underrun !== 1'b0) begin
            errors++; $display("FAIL full_unr0 got %b want 0", q_underrun);
        end
        step('0, 0, 0, wd(5, 0, 1));
        checks++;
        if (out !== wd(5, 0, 1) || drop !== 1'b0 || q_underrun !== 1'b1) begin
            errors++;
            $display("FAIL full_empty got %h/%b unr %b want fwd unr 1",
                     out, drop, q_underrun);
        end
    endtask

    task automatic test_one_word_missing_eop();
        avln_st fw [7];
        logic   ed [7];
        logic   ev [7];
        avln_st ex;
        do_reset();
        step(wd(0, 0, 1), 1, 1, '0);
        step(wd(1, 0, 3), 0, 0, '0);
        step(wd(1, 1, 3), 0, 0, '0);
        step(wd(2, 0, 3), 0, 0, '0);
        step(wd(2, 1, 3), 1, 1, '0);
        step(wd(2, 2, 3), 0, 0, '0);
        fw[0] = wd(0, 0, 1); ed[0] = 1; ev[0] = 0;
        fw[1] = wd(1, 0, 3); ed[1] = 0; ev[1] = 1;
        fw[2] = wd(1, 1, 3); ed[2] = 0; ev[2] = 1;
        fw[3] = wd(2, 0, 3); ed[3] = 1; ev[3] = 0;
        fw[4] = wd(2, 1, 3); ed[4] = 1; ev[4] = 0;
        fw[5] = wd(2, 2, 3); ed[5] = 1; ev[5] = 0;
        fw[6] = wd(3, 1, 3); ed[6] = 0; ev[6] = 0;
        for (int i = 0; i < 7; i++) begin
            step('0, 0, 0, fw[i]);
            ex = fw[i];
            ex.valid = ev[i];
            checks++;
            if (out !== ex || drop !== ed[i]) begin
                errors++;
                $display("FAIL order_word i%0d got %h/%b want %h/%b",
                         i, out, drop, ex, ed[i]);
            end
        end
        checks++;
        if (pass_count !== 1 || drop_count !== 2 || q_underrun !== 1'b0) begin
            errors++;
            $display("FAIL order_cnt got p%0d d%0d u%b want p1 d2 u0",
                     pass_count, drop_count, q_underrun);
        end
    endtask

    task automatic test_reset_mid();
        logic h;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            h = (k == 2);
            step(wd(0, k, 8), h, h, '0);
        end
        for (int k = 0; k < 4; k++) begin
            step('0, 0, 0, wd(0, k, 8));
            checks++;
            if (out !== sup(wd(0, k, 8)) || drop !== 1'b1) begin
                errors++;
                $display("FAIL mid_pre k%0d got %h/%b want drop", k, out, drop);
            end
        end
        checks++;
        if (drop_count !== 1) begin
            errors++; $display("FAIL mid_dcnt got %0d want 1", drop_count);
        end
        #2;
        reset_n = 1'b0;
        in = '0; fifo_out = '0; valid = 0; found = 0; start = 0;
        #1;
        checks++;
        if (out !== '0 || drop !== 1'b0 || drop_count !== '0 || pass_count !== '0) begin
            errors++;
            $display("FAIL mid_async got %h/%b d%0d p%0d want all 0",
                     out, drop, drop_count, pass_count);
        end
        @(negedge sys_clk);
        reset_n = 1'b1;
        for (int k = 4; k < 8; k++) begin
            step(wd(1, k - 4, 8), 0, 0, wd(0, k, 8));
            checks++;
            if (out !== sup(wd(0, k, 8)) || drop !== 1'b0) begin
                errors++;
                $display("FAIL mid_tail k%0d got %h/%b want suppressed/0",
                         k, out, drop);
            end
        end
        for (int k = 4; k < 8; k++) step(wd(1, k, 8), 0, 0, '0);
        for (int k = 0; k < 8; k++) begin
            step('0, 0, 0, wd(1, k, 8));
            checks++;
            if (out !== wd(1, k, 8) || drop !== 1'b0) begin
                errors++;
                $display("FAIL mid_next k%0d got %h/%b want %h/0",
                         k, out, drop, wd(1, k, 8));
            end
        end
        checks++;
        if (pass_count !== 1 || drop_count !== 0 || q_underrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_cnt got p%0d d%0d u%b want p1 d0 u0",
                     pass_count, drop_count, q_underrun);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pass();
        test_drop();
        test_overflow_underrun();
        test_full_push_pop();
        test_one_word_missing_eop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
